// File: rtl/iq_mixer_tdm_sched_pkg.sv
// Shared definitions for the TDM IQ mixer scheduler: FSM states and tag layout.
// A tag is packed as {valid, chan[CW-1:0], iq}, valid in the MSB.
package iq_mixer_tdm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int TAG_IQ_LSB   = 0;
  localparam int TAG_CHAN_LSB = 1;

  function automatic int chan_w(input int nchan);
    return (nchan > 1) ? $clog2(nchan) : 1;
  endfunction

  function automatic int tag_w(input int cw);
    return cw + 2;
  endfunction

endpackage

// File: rtl/iq_mixer_tdm_sched_tag_delay.sv
// Fixed-depth shift register carrying issue tags alongside the shared mixer pipeline.
// inner_busy reports valid tags in every stage except the output stage.
module tag_delay #(
  parameter int TW    = 4,
  parameter int DEPTH = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] tag_in,
  output logic [TW-1:0] tag_out,
  output logic          inner_busy
);

  logic [TW-1:0] line_q [DEPTH];
  logic [TW-1:0] line_d [DEPTH];

  always_comb begin
    line_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      line_d[i] = line_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        line_q[i] <= '0;
      end else begin
        line_q[i] <= line_d[i];
      end
    end
  end

  always_comb begin
    inner_busy = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      inner_busy = inner_busy | line_q[i][TW-1];
    end
  end

  assign tag_out = line_q[DEPTH-1];

endmodule

// File: rtl/iq_mixer_tdm_sched.sv
// Time-division scheduler sharing one external mixer across NCHAN channels and both LO phases.
// Issues one (sample, LO) pair per clock and re-tags returning products as a serial stream.
module iq_mixer_tdm_sched
  import iq_mixer_tdm_sched_pkg::*;
#(
  parameter int NCHAN   = 4,
  parameter int DWI     = 16,
  parameter int DWLO    = 18,
  parameter int DAVR    = 4,
  parameter int MIX_LAT = 3,
  localparam int CW     = chan_w(NCHAN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strobe_in,
  input  logic [NCHAN*DWI-1:0] adc,
  input  logic [DWLO-1:0]      cos,
  input  logic [DWLO-1:0]      sin,
  input  logic [NCHAN-1:0]     chan_mask,
  input  logic                 ovr_clr,
  output logic [DWI-1:0]       mix_adc,
  output logic [DWLO-1:0]      mix_lo,
  input  logic [DWI+DAVR-1:0]  mix_result,
  output logic                 out_valid,
  output logic [DWI+DAVR-1:0]  out_data,
  output logic [CW-1:0]        out_chan,
  output logic                 out_iq,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overrun
);

  localparam int TW = tag_w(CW);
  localparam int DW = DWI + DAVR;

  state_e               state_q, state_d;
  logic [NCHAN*DWI-1:0] adc_q, adc_d;
  logic [DWLO-1:0]      cos_q, cos_d;
  logic [DWLO-1:0]      sin_q, sin_d;
  logic [NCHAN-1:0]     mask_q, mask_d;
  logic [CW-1:0]        cur_chan_q, cur_chan_d;
  logic                 cur_iq_q, cur_iq_d;
  logic [DWI-1:0]       mix_adc_q, mix_adc_d;
  logic [DWLO-1:0]      mix_lo_q, mix_lo_d;
  logic                 ovr_q, ovr_d;
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic [CW-1:0]        out_chan_q, out_chan_d;
  logic                 out_iq_q, out_iq_d;
  logic                 frame_done_q, frame_done_d;

  logic [CW-1:0] first_chan;
  logic [CW-1:0] next_chan;
  logic          next_found;
  logic [TW-1:0] push_tag;
  logic [TW-1:0] exit_tag;
  logic          exit_valid;
  logic          line_inner_busy;

  tag_delay #(
    .TW    (TW),
    .DEPTH (MIX_LAT)
  ) u_tag_delay (
    .clk        (clk),
    .rst        (rst),
    .tag_in     (push_tag),
    .tag_out    (exit_tag),
    .inner_busy (line_inner_busy)
  );

  // Descending scans leave the lowest qualifying channel as the winner.
  always_comb begin
    first_chan = '0;
    for (int k = NCHAN - 1; k >= 0; k--) begin
      if (chan_mask[k]) begin
        first_chan = CW'(k);
      end
    end
  end

  always_comb begin
    next_chan  = '0;
    next_found = 1'b0;
    for (int k = NCHAN - 1; k >= 0; k--) begin
      if (mask_q[k] && (k > int'(cur_chan_q))) begin
        next_chan  = CW'(k);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    adc_d      = adc_q;
    cos_d      = cos_q;
    sin_d      = sin_q;
    mask_d     = mask_q;
    cur_chan_d = cur_chan_q;
    cur_iq_d   = cur_iq_q;
    mix_adc_d  = mix_adc_q;
    mix_lo_d   = mix_lo_q;
    push_tag   = '0;

    ovr_d = ovr_q;
    if (ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (strobe_in && (state_q != ST_IDLE)) begin
      ovr_d = 1'b1;
    end

    // The mix registers always hold the pair being issued in the current ISSUE cycle,
    // so the next pair is loaded one cycle ahead.
    case (state_q)
      ST_IDLE: begin
        if (strobe_in && (|chan_mask)) begin
          adc_d      = adc;
          cos_d      = cos;
          sin_d      = sin;
          mask_d     = chan_mask;
          cur_chan_d = first_chan;
          cur_iq_d   = 1'b0;
          mix_adc_d  = adc[int'(first_chan)*DWI +: DWI];
          mix_lo_d   = cos;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        push_tag = {1'b1, cur_chan_q, cur_iq_q};
        if (!cur_iq_q) begin
          cur_iq_d = 1'b1;
          mix_lo_d = sin_q;
        end else if (next_found) begin
          cur_chan_d = next_chan;
          cur_iq_d   = 1'b0;
          mix_adc_d  = adc_q[int'(next_chan)*DWI +: DWI];
          mix_lo_d   = cos_q;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!line_inner_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // In DRAIN no new tags enter, so a lone tag at the exit is the frame's last one.
  always_comb begin
    exit_valid   = exit_tag[TW-1];
    out_valid_d  = exit_valid;
    frame_done_d = exit_valid && (state_q == ST_DRAIN) && !line_inner_busy;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_iq_d     = out_iq_q;
    if (exit_valid) begin
      out_data_d = mix_result;
      out_chan_d = exit_tag[TAG_CHAN_LSB +: CW];
      out_iq_d   = exit_tag[TAG_IQ_LSB];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      adc_q        <= '0;
      cos_q        <= '0;
      sin_q        <= '0;
      mask_q       <= '0;
      cur_chan_q   <= '0;
      cur_iq_q     <= 1'b0;
      mix_adc_q    <= '0;
      mix_lo_q     <= '0;
      ovr_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_iq_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      adc_q        <= adc_d;
      cos_q        <= cos_d;
      sin_q        <= sin_d;
      mask_q       <= mask_d;
      cur_chan_q   <= cur_chan_d;
      cur_iq_q     <= cur_iq_d;
      mix_adc_q    <= mix_adc_d;
      mix_lo_q     <= mix_lo_d;
      ovr_q        <= ovr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_iq_q     <= out_iq_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mix_adc    = mix_adc_q;
  assign mix_lo     = mix_lo_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_chan   = out_chan_q;
  assign out_iq     = out_iq_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_iq_mixer_tdm_sched.sv
// Scoreboard bench for iq_mixer_tdm_sched with an external 3-cycle product mixer.
// Expected results are queued by a frame-level model at strobe time and popped on out_valid.
module tb_iq_mixer_tdm_sched;

  localparam int NCHAN   = 4;
  localparam int DWI     = 16;
  localparam int DWLO    = 18;
  localparam int DAVR    = 4;
  localparam int MIX_LAT = 3;
  localparam int CW      = 2;
  localparam int DW      = DWI + DAVR;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 strobe_in = 1'b0;
  logic [NCHAN*DWI-1:0] adc = '0;
  logic [DWLO-1:0]      cos_v = '0;
  logic [DWLO-1:0]      sin_v = '0;
  logic [NCHAN-1:0]     chan_mask = '0;
  logic                 ovr_clr = 1'b0;
  logic [DWI-1:0]       mix_adc;
  logic [DWLO-1:0]      mix_lo;
  logic [DW-1:0]        mix_result;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic [CW-1:0]        out_chan;
  logic                 out_iq;
  logic                 frame_done;
  logic                 busy;
  logic                 overrun;

  iq_mixer_tdm_sched #(
    .NCHAN   (NCHAN),
    .DWI     (DWI),
    .DWLO    (DWLO),
    .DAVR    (DAVR),
    .MIX_LAT (MIX_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .strobe_in  (strobe_in),
    .adc        (adc),
    .cos        (cos_v),
    .sin        (sin_v),
    .chan_mask  (chan_mask),
    .ovr_clr    (ovr_clr),
    .mix_adc    (mix_adc),
    .mix_lo     (mix_lo),
    .mix_result (mix_result),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_iq     (out_iq),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mixf(input logic signed [DWI-1:0] a,
                                         input logic signed [DWLO-1:0] b);
    logic signed [DWI+DWLO-1:0] p;
    p = a * b;
    return p[DW-1:0];
  endfunction

  // External shared mixer: registered product, MIX_LAT cycles.
  logic [DW-1:0] m_q [MIX_LAT];
  always @(posedge clk) begin
    m_q[0] <= mixf(mix_adc, mix_lo);
    for (int i = 1; i < MIX_LAT; i++) m_q[i] <= m_q[i-1];
  end
  assign mix_result = m_q[MIX_LAT-1];

  typedef struct {
    logic [DW-1:0] data;
    int            chan;
    logic          iq;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   free_at = 0;
  logic ovr_exp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe during the current cycle; the model decides accept/ignore from the frame timing rules.
  task automatic send(input logic [3:0] m, input logic [63:0] a,
                      input logic [17:0] c, input logic [17:0] s, input logic clr);
    int   t;
    int   j;
    int   mcnt;
    exp_t e;
    t = cyc;
    strobe_in = 1'b1;
    chan_mask = m;
    adc       = a;
    cos_v     = c;
    sin_v     = s;
    ovr_clr   = clr;
    if (clr) ovr_exp = 1'b0;
    if (t < free_at) begin
      ovr_exp = 1'b1;
    end else if (m != 4'd0) begin
      j    = 0;
      mcnt = $countones(m);
      for (int ch = 0; ch < NCHAN; ch++) begin
        if (m[ch]) begin
          for (int iq = 0; iq < 2; iq++) begin
            e.data = mixf(a[ch*DWI +: DWI], (iq == 1) ? s : c);
            e.chan = ch;
            e.iq   = (iq == 1);
            e.last = (j == 2*mcnt - 1);
            e.cyc  = t + 2 + j + MIX_LAT;
            q.push_back(e);
            j++;
          end
        end
      end
      free_at = t + 1 + 2*mcnt + MIX_LAT;
    end
    @(posedge clk);
    #1;
    strobe_in = 1'b0;
    ovr_clr   = 1'b0;
    check("overrun_after_strobe", 64'(overrun), 64'(ovr_exp));
  endtask

  task automatic pulse_clr();
    ovr_clr = 1'b1;
    ovr_exp = 1'b0;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    check("overrun_cleared", 64'(overrun), 64'(ovr_exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_done"}, 64'({out_valid, frame_done}), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_tag"}, 64'({out_chan, out_iq}), 64'd0);
    check({tag, "_busy_ovr"}, 64'({busy, overrun}), 64'd0);
    check({tag, "_mix"}, 64'({mix_adc, mix_lo}), 64'd0);
  endtask

  task automatic mid_reset();
    int r;
    r = cyc;
    rst = 1'b1;
    while (q.size() > 0 && q[$].cyc > r) q.pop_back();
    free_at = 0;
    ovr_exp = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("after_mid_reset");
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: chan %0d iq %0d data 0x%0h at cycle %0d, expected none",
                 out_chan, out_iq, out_data, cyc);
      end else begin
        mon_e = q.pop_front();
        check("out_data", 64'(out_data), 64'(mon_e.data));
        check("out_chan_iq", 64'({out_chan, out_iq}), 64'({mon_e.chan[1:0], mon_e.iq}));
        check("frame_done", 64'(frame_done), 64'(mon_e.last));
        check("out_cycle", 64'(cyc), 64'(mon_e.cyc));
        if (frame_done) check("busy_at_frame_done", 64'(busy), 64'd0);
      end
    end else if (frame_done) begin
      check("frame_done_without_valid", 64'(frame_done), 64'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [17:0] COS_P = 18'sd1000;
  localparam logic [17:0] SIN_N = -18'sd1000;
  localparam logic [63:0] ADC_D = {16'd400, 16'd300, 16'd200, 16'd100};

  initial begin
    logic [3:0]  m;
    logic [63:0] a;
    int          mc;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");

    // Full frame, then sparse mask.
    send(4'hF, ADC_D, COS_P, SIN_N, 1'b0);
    idle(20);
    send(4'b1010, ADC_D, COS_P, SIN_N, 1'b0);
    idle(12);

    // Overrun: strobe at cycle 6 of a frame, then clear, then clear+set in one cycle.
    send(4'hF, ADC_D, COS_P, SIN_N, 1'b0);
    idle(5);
    send(4'hF, {4{16'h7FFF}}, SIN_N, COS_P, 1'b0);
    idle(15);
    pulse_clr();
    send(4'hF, {16'd9, 16'd8, 16'd7, 16'd6}, COS_P, SIN_N, 1'b0);
    idle(2);
    send(4'hF, ADC_D, COS_P, SIN_N, 1'b1);
    idle(15);
    pulse_clr();

    // Minimum period back-to-back, then one cycle too short.
    send(4'hF, ADC_D, COS_P, SIN_N, 1'b0);
    idle(11);
    send(4'hF, {16'd1, 16'd2, 16'd3, 16'd4}, SIN_N, COS_P, 1'b0);
    idle(11);
    send(4'hF, ADC_D, 18'd5, 18'd7, 1'b0);
    idle(10);
    send(4'hF, ADC_D, COS_P, SIN_N, 1'b0);
    idle(20);
    pulse_clr();

    // Reset at cycle 4 of a frame, then a clean frame.
    send(4'hF, ADC_D, COS_P, SIN_N, 1'b0);
    idle(3);
    mid_reset();
    idle(15);
    send(4'b0110, ADC_D, COS_P, SIN_N, 1'b0);
    idle(20);

    // Empty mask strobe is ignored entirely.
    send(4'h0, ADC_D, COS_P, SIN_N, 1'b0);
    check("busy_after_mask0", 64'(busy), 64'd0);
    idle(5);

    // Randomized frames with gaps around the minimum period.
    for (int it = 0; it < 40; it++) begin
      m  = 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      mc = $countones(m);
      send(m, a, 18'($urandom), 18'($urandom), ($urandom_range(0, 7) == 0));
      idle($urandom_range(2*mc + MIX_LAT - 2, 2*mc + MIX_LAT + 3));
    end

    idle(25);
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iq_mixer_tdm_sched.md
# iq_mixer_tdm_sched

Time-division scheduler that shares one external `mixer` instance across NCHAN ADC channels and both LO phases, as an alternative to instantiating 2·NCHAN mixers. On each sample strobe it latches all channel samples plus cos/sin. It then issues one (sample, LO) pair per clock to the shared mixer. Returning products are tagged with channel and I/Q and emitted as a serial stream for the downstream CIC/accumulator stage.

## Interface
- NCHAN, 4: channels per frame (≥1)
- DWI, 16: ADC sample width
- DWLO, 18: LO (cos/sin) width
- DAVR, 4: guard bits; mixer result width is DWI+DAVR
- MIX_LAT, 3: shared-mixer latency, cycles from `mix_adc`/`mix_lo` to `mix_result` (≥1)
- CW, $clog2(NCHAN) (min 1): channel-index width (localparam)

Ports (one clock, `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- strobe_in  in  1  new ADC sample frame valid
- adc  in  NCHAN·DWI  flattened signed samples, channel k at [k·DWI +: DWI]
- cos, sin  in  DWLO  signed LO, sampled with strobe_in
- chan_mask  in  NCHAN  enabled channels, sampled with strobe_in
- ovr_clr  in  1  clears `overrun`
- mix_adc  out  DWI  to shared mixer `adcf`
- mix_lo  out  DWLO  to shared mixer `mult`
- mix_result  in  DWI+DAVR  from shared mixer `mixout`
- out_valid  out  1  result strobe
- out_data  out  DWI+DAVR  signed product
- out_chan  out  CW  channel of out_data
- out_iq  out  1  0 = cos (I), 1 = sin (Q)
- frame_done  out  1  one-cycle pulse with the last result of a frame
- busy  out  1  high when not IDLE
- overrun  out  1  sticky: strobe arrived while busy

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE, strobe_in=1, chan_mask≠0: latch adc, cos, sin, chan_mask → ISSUE. If chan_mask=0, ignore the strobe: no outputs, no overrun.
- ISSUE: walk enabled channels in ascending order. For each channel, issue cos, then sin, on consecutive cycles. Masked channels are skipped with no gap cycles. Each issue pushes tag {valid, chan, iq} into a MIX_LAT-deep delay line. After the final issue → DRAIN.
- DRAIN: wait until the delay line is empty → IDLE.
- Output: when the tag exits the delay line, register mix_result into out_data and the tag into out_chan/out_iq, and assert out_valid. frame_done is asserted together with the last tag of the frame.
- Non-issue cycles: mix_adc and mix_lo hold their last values; products returned on those cycles are discarded.
- strobe_in while busy: ignored; overrun←1. Overrun holds until ovr_clr. If ovr_clr and a new overrun occur in the same cycle, set wins.
- Arithmetic: no scaling; out_data is mix_result bit-exact.

## Timing
- Strobe accepted at cycle 0; capture registers are loaded at the edge ending cycle 0.
- Issue j (j = 0..2M−1, M = enabled channel count) drives mix_adc/mix_lo during cycle 1+j.
- Result j: out_valid at cycle 2+j+MIX_LAT. Latency from strobe to first result is MIX_LAT+2.
- frame_done at cycle 1+2M+MIX_LAT. busy falls on that same cycle, and a strobe on that cycle is accepted.
- Minimum strobe period without overrun: 2M+MIX_LAT+1.
- Reset values: all outputs 0, state IDLE, delay line invalid. Reset mid-frame drops in-flight tags; no out_valid occurs after reset for a pre-reset issue.

## Structure
- Shared package/header `iq_tdm_defs.vh`: state encodings (IDLE/ISSUE/DRAIN) and the tag field layout {valid, chan[CW], iq}.
- One sub-module, `tag_delay`: parameterised-depth shift register of tags with synchronous reset of the valid bits. The top level holds the FSM, mask scan (priority find-next from current channel), capture registers and the output register.

## Test plan
- NCHAN=4, MIX_LAT=3, mask=4'b1111, adc={400,300,200,100}, cos=1000, sin=−1000, bench mixer = registered product with 3-cycle latency → 8 results at cycles 5..12, order (0,I),(0,Q),(1,I)…(3,Q), frame_done at cycle 12.
- mask=4'b1010 → 4 results (ch1 I/Q, ch3 I/Q) at cycles 5..8, frame_done at 8, busy low at 8.
- Strobe at cycle 6 of a full frame → ignored, overrun=1, original 8 results unchanged. ovr_clr pulse → overrun=0. ovr_clr plus second overrun in the same cycle → overrun stays 1.
- Back-to-back strobes at period 12 (the minimum for M=4) → continuous frames, no overrun. Period 11 → overrun set.
- rst asserted at cycle 4 of a frame → no out_valid or frame_done afterward, all outputs 0 the next cycle, and the next strobe runs a clean frame.
- mask=0 strobe → no activity, busy stays 0, overrun stays 0.
